// File: rtl/jt6295_cmdq.sv
// jt6295_cmdq -- command scheduler in front of the jt6295 CPU write port.
//
// Queues play/stop requests, turns each into MSM6295 command bytes and drives
// wrn/din with a fixed low time (WR_LEN clk cycles) and a minimum high time
// after every write (WR_GAP cen pulses).
//
// Optional feature: define JT6295_CMDQ_BUSYCHK_EN to hold a play request at the
// head of the queue while any of its target channels reports busy on oki_dout.
// Without the macro, oki_dout is ignored.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cen                jt6295 clock enable (paces the inter-write gap)
//   req_valid/ready    request handshake (ready = FIFO can take an entry)
//   req_stop           1 = stop request, 0 = play request
//   req_phrase[6:0]    phrase number (play only)
//   req_ch[3:0]        channel mask, bit0 = ch1
//   req_att[3:0]       attenuation code (play only)
//   flush              discard every queued request that has not started
//   oki_dout[7:0]      jt6295 status; bits 3:0 = channel busy
//   wrn, din[7:0]      jt6295 write strobe (active low) and data
//   pending[AW:0]      number of requests waiting in the FIFO
//   bad_req            one-cycle pulse when an invalid request is discarded
module jt6295_cmdq #(
  parameter int AW     = 3,
  parameter int WR_LEN = 4,
  parameter int WR_GAP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_stop,
  input  logic [6:0]    req_phrase,
  input  logic [3:0]    req_ch,
  input  logic [3:0]    req_att,
  input  logic          flush,
  input  logic [7:0]    oki_dout,
  output logic          wrn,
  output logic [7:0]    din,
  output logic [AW:0]   pending,
  output logic          bad_req
);

  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (WR_LEN > WR_GAP) ? WR_LEN : WR_GAP;
  localparam int CW    = $clog2(CMAX + 1);
  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] LEN_M1   = CW'(WR_LEN - 1);
  localparam logic [CW-1:0] GAP_M1   = CW'(WR_GAP - 1);
  localparam logic [CW-1:0] TCNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR1  = 3'd1,
    ST_GAP1 = 3'd2,
    ST_WR2  = 3'd3,
    ST_GAP2 = 3'd4
  } state_t;

  // FIFO entry layout: {stop, phrase[6:0], ch[3:0], att[3:0]}
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;

  state_t        r_state, w_state_nxt;
  logic          r_wrn, w_wrn_nxt;
  logic [7:0]    r_din, w_din_nxt;
  logic [CW-1:0] r_tcnt, w_tcnt_nxt;
  logic          r_bad, w_bad_nxt;
  logic [7:0]    r_byte1, w_byte1_nxt;
  logic          r_stop, w_stop_nxt;
  logic          w_pop, w_push, w_empty, w_full;

  logic [15:0]   w_head;
  logic          w_h_stop, w_invalid, w_eligible;
  logic [6:0]    w_h_ph;
  logic [3:0]    w_h_ch, w_h_att;
  logic [7:0]    w_byte0;

  assign w_head   = r_mem[r_rptr];
  assign w_h_stop = w_head[15];
  assign w_h_ph   = w_head[14:8];
  assign w_h_ch   = w_head[7:4];
  assign w_h_att  = w_head[3:0];
  assign w_byte0  = w_h_stop ? {1'b0, w_h_ch, 3'b000} : {1'b1, w_h_ph};

  assign w_invalid = w_h_stop ? (w_h_ch == 4'd0)
                              : ((w_h_ph == 7'd0) || (w_h_ch == 4'd0));

`ifdef JT6295_CMDQ_BUSYCHK_EN
  // A play waits until none of its channels is busy; stops never wait.
  assign w_eligible = w_h_stop || ((oki_dout[3:0] & w_h_ch) == 4'd0);
  logic w_unused_dout;
  assign w_unused_dout = ^oki_dout[7:4];
`else
  assign w_eligible = 1'b1;
  logic w_unused_dout;
  assign w_unused_dout = ^oki_dout;
`endif

  assign w_empty = (r_cnt == {(AW+1){1'b0}});
  assign w_full  = (r_cnt == FULL_CNT);
  // A pop this cycle frees a slot, so a full FIFO can still accept.
  assign req_ready = ~w_full | w_pop;
  // flush wins over a simultaneous request.
  assign w_push    = req_valid & req_ready & ~flush;

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {req_stop, req_phrase, req_ch, req_att};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= {AW{1'b0}};
      r_rptr <= {AW{1'b0}};
      r_cnt  <= {(AW+1){1'b0}};
    end else if (flush) begin
      r_wptr <= {AW{1'b0}};
      r_rptr <= {AW{1'b0}};
      r_cnt  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and write-port next values
  always_comb begin
    w_state_nxt = r_state;
    w_wrn_nxt   = r_wrn;
    w_din_nxt   = r_din;
    w_tcnt_nxt  = r_tcnt;
    w_bad_nxt   = 1'b0;
    w_pop       = 1'b0;
    w_byte1_nxt = r_byte1;
    w_stop_nxt  = r_stop;
    case (r_state)
      ST_IDLE: begin
        // Flush takes priority: the head has not started, so it is discarded.
        if (!flush && !w_empty) begin
          if (w_invalid) begin
            w_pop     = 1'b1;
            w_bad_nxt = 1'b1;
          end else if (w_eligible) begin
            w_pop       = 1'b1;
            w_din_nxt   = w_byte0;
            w_wrn_nxt   = 1'b0;
            w_tcnt_nxt  = LEN_M1;
            w_byte1_nxt = {w_h_ch, w_h_att};
            w_stop_nxt  = w_h_stop;
            w_state_nxt = ST_WR1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR1, ST_WR2: begin
        if (r_tcnt == {CW{1'b0}}) begin
          w_wrn_nxt   = 1'b1;
          w_state_nxt = (r_state == ST_WR1) ? ST_GAP1 : ST_GAP2;
        end else begin
          w_tcnt_nxt  = r_tcnt - TCNT_ONE;
        end
      end
      ST_GAP1, ST_GAP2: begin
        // r_tcnt was left at zero by WRx; it now counts cen pulses.
        if (cen) begin
          if (r_tcnt == GAP_M1) begin
            if (r_state == ST_GAP1 && !r_stop) begin
              w_din_nxt   = r_byte1;
              w_wrn_nxt   = 1'b0;
              w_tcnt_nxt  = LEN_M1;
              w_state_nxt = ST_WR2;
            end else begin
              w_tcnt_nxt  = {CW{1'b0}};
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + TCNT_ONE;
          end
        end else begin
          w_tcnt_nxt = r_tcnt;
        end
      end
      default: begin
        w_wrn_nxt   = 1'b1;
        w_tcnt_nxt  = {CW{1'b0}};
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered write-port outputs and sequence context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrn   <= 1'b1;
      r_din   <= 8'd0;
      r_tcnt  <= {CW{1'b0}};
      r_bad   <= 1'b0;
      r_byte1 <= 8'd0;
      r_stop  <= 1'b0;
    end else begin
      r_wrn   <= w_wrn_nxt;
      r_din   <= w_din_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_bad   <= w_bad_nxt;
      r_byte1 <= w_byte1_nxt;
      r_stop  <= w_stop_nxt;
    end
  end

  assign wrn     = r_wrn;
  assign din     = r_din;
  assign pending = r_cnt;
  assign bad_req = r_bad;

endmodule

// File: tb/tb_jt6295_cmdq.sv
// Self-checking bench for jt6295_cmdq: directed scenarios plus random traffic
// checked against a queue-based model of the expected jt6295 byte stream.
module tb_jt6295_cmdq;
  localparam int AW = 3, WR_LEN = 4, WR_GAP = 2;

  logic       clk = 1'b0, rst_n = 1'b1, cen = 1'b0;
  logic       req_valid = 1'b0, req_stop = 1'b0, flush = 1'b0;
  logic [6:0] req_phrase = 7'd0;
  logic [3:0] req_ch = 4'd0, req_att = 4'd0;
  logic [7:0] oki_dout = 8'd0;
  logic       req_ready, wrn, bad_req;
  logic [7:0] din;
  logic [AW:0] pending;

  jt6295_cmdq #(.AW(AW), .WR_LEN(WR_LEN), .WR_GAP(WR_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .req_valid(req_valid),
    .req_ready(req_ready), .req_stop(req_stop), .req_phrase(req_phrase),
    .req_ch(req_ch), .req_att(req_att), .flush(flush), .oki_dout(oki_dout),
    .wrn(wrn), .din(din), .pending(pending), .bad_req(bad_req)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  int bad_exp = 0, bad_seen = 0, wr_cnt = 0;
  bit cen_run = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // cen pacing: roughly one pulse in three while running, stuck low otherwise
  always @(negedge clk) cen = cen_run ? ($urandom_range(0, 2) == 0) : 1'b0;

  // Expected bytes for one accepted request, straight from the command format
  task automatic model_add(input bit stop, input logic [6:0] ph, input logic [3:0] ch, input logic [3:0] att);
    if (stop) begin
      if (ch == 4'd0) bad_exp++;
      else exp_q.push_back({1'b0, ch, 3'b000});
    end else begin
      if (ph == 7'd0 || ch == 4'd0) bad_exp++;
      else begin
        exp_q.push_back({1'b1, ph});
        exp_q.push_back({ch, att});
      end
    end
  endtask

  // Bus monitor: byte order, low width, gap length and din stability
  logic prev_wrn = 1'b1;
  logic [7:0] prev_din = 8'd0;
  int low_n = 0, gap_n = 1000;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (prev_wrn && cen) gap_n++;
      if (bad_req) bad_seen++;
      if (prev_wrn && !wrn) begin
        wr_cnt++;
        chk("gap_len", 32'(gap_n >= WR_GAP), 32'd1);
        if (exp_q.size() == 0) chk("wr_extra", {24'd0, din}, 32'hFFFF_FFFF);
        else chk("wr_byte", {24'd0, din}, {24'd0, exp_q.pop_front()});
        low_n = 1;
      end else if (!prev_wrn && !wrn) begin
        low_n++;
        chk("din_hold", {24'd0, din}, {24'd0, prev_din});
      end else if (!prev_wrn && wrn) begin
        chk("low_len", low_n, WR_LEN);
        chk("din_rise", {24'd0, din}, {24'd0, prev_din});
        gap_n = 0;
      end else if (din !== prev_din) begin
        chk("din_idle", {24'd0, din}, {24'd0, prev_din});
      end
      prev_wrn = wrn;
      prev_din = din;
    end
  end

  // Present one request; leaves req_valid high so pushes can run back-to-back
  task automatic push(input bit stop, input logic [6:0] ph, input logic [3:0] ch, input logic [3:0] att);
    bit ok = 1'b0;
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_stop = stop; req_phrase = ph; req_ch = ch; req_att = att;
    while (!ok && n < 3000) begin
      ok = req_ready;
      @(posedge clk);
      if (!ok) begin
        @(negedge clk);
        n++;
      end
    end
    if (ok) model_add(stop, ph, ch, att);
    else chk("ready_to", 32'd0, 32'd1);
  endtask

  task automatic end_push();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    cen_run = 1'b1;
    while ((exp_q.size() != 0 || pending != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_to", 32'(n < 5000), 32'd1);
    repeat (30) @(negedge clk);
    chk("drain_pend", 32'(pending), 32'd0);
    chk("drain_q", exp_q.size(), 32'd0);
    chk("drain_bad", bad_seen, bad_exp);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wrn", 32'(wrn), 32'd1);
    chk("rst_din", {24'd0, din}, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_bad", 32'(bad_req), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Play 0x14 on ch1: latency and 0x94/0x10 pair
    cen_run = 1'b1;
    push(1'b0, 7'h14, 4'h1, 4'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("lat_pre", 32'(wrn), 32'd1);
    @(negedge clk);
    chk("lat_wrn", 32'(wrn), 32'd0);
    chk("lat_din", {24'd0, din}, 32'h94);
    drain();

    // Stop all channels: single 0x78 write
    base = wr_cnt;
    push(1'b1, 7'h00, 4'hF, 4'h0);
    end_push();
    drain();
    chk("stop_cnt", wr_cnt - base, 32'd1);

    // Invalid play (phrase 0) then stop ch2
    base = wr_cnt;
    push(1'b0, 7'h00, 4'h1, 4'h5);
    push(1'b1, 7'h00, 4'h2, 4'h0);
    end_push();
    drain();
    chk("bad_cnt", wr_cnt - base, 32'd1);

    // Fill: cen held low so the first play stalls in its gap
    cen_run = 1'b0;
    repeat (2) @(negedge clk);
    push(1'b0, 7'h01, 4'h1, 4'h0);
    for (int i = 0; i < 7; i++) push(1'b0, 7'(i + 2), 4'h1, 4'(i));
    @(negedge clk);
    req_valid = 1'b0;
    chk("fill7_pend", 32'(pending), 32'd7);
    chk("fill7_ready", 32'(req_ready), 32'd1);
    push(1'b1, 7'h00, 4'h3, 4'h0);
    end_push();
    chk("fill8_pend", 32'(pending), 32'd8);
    chk("fill8_ready", 32'(req_ready), 32'd0);
    chk("fill8_wrn", 32'(wrn), 32'd1);
    drain();

    // Flush during WR1 of play 0x81/0x20 with three queued behind it
    push(1'b0, 7'h01, 4'h2, 4'h0);
    for (int i = 0; i < 3; i++) push(1'b0, 7'(8'h30 + i), 4'h1, 4'h1);
    @(negedge clk);
    req_phrase = 7'h55;
    flush = 1'b1;
    chk("fl_wrn", 32'(wrn), 32'd0);
    chk("fl_ready", 32'(req_ready), 32'd1);
    repeat (6) void'(exp_q.pop_back());
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    chk("fl_pend", 32'(pending), 32'd0);
    drain();

    // Channel 1 reported busy
    oki_dout = 8'h01;
    base = wr_cnt;
    push(1'b0, 7'h05, 4'h1, 4'h3);
    end_push();
    repeat (30) @(negedge clk);
`ifdef JT6295_CMDQ_BUSYCHK_EN
    chk("busy_hold", wr_cnt - base, 32'd0);
`else
    chk("busy_ign", 32'(wr_cnt - base >= 1), 32'd1);
`endif
    oki_dout = 8'h00;
    drain();

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      int r;
      bit st;
      logic [6:0] ph;
      logic [3:0] ch;
      r  = $urandom_range(0, 9);
      st = (r < 3);
      ph = (r == 9) ? 7'd0 : 7'($urandom_range(1, 127));
      ch = (r == 8) ? 4'd0 : 4'($urandom_range(1, 15));
`ifndef JT6295_CMDQ_BUSYCHK_EN
      oki_dout = 8'($urandom);
`endif
      push(st, ph, ch, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) begin
        end_push();
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    end_push();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
